// File: rtl/maxpool_2x2_stage.sv
// maxpool_2x2_stage: 2x2 stride-2 max pooling over CHANNELS MAP_DIM x MAP_DIM signed
// feature maps held in a BRAM, streaming one pooled value per window over valid/ready.
// Ports: clk/reset (async, active-high); start pulse; BRAM read port rd_en/rd_addr/rd_data
// (1-cycle read latency); out_valid/out_ready/out_data with out_chan/out_row/out_col/out_last
// tags; busy/done status.
// Optional macro MAXPOOL_SAT8_EN: clamp out_data to 0..255 after the full-width max.
module maxpool_2x2_stage #(
  parameter int DWIDTH   = 17,
  parameter int MAP_DIM  = 6,
  parameter int CHANNELS = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              rd_en,
  output logic [7:0]        rd_addr,
  input  logic [DWIDTH-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] out_data,
  output logic [1:0]        out_chan,
  output logic [1:0]        out_row,
  output logic [1:0]        out_col,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam int         POOL    = MAP_DIM / 2;
  localparam logic [1:0] LAST_CH = 2'(CHANNELS - 1);
  localparam logic [1:0] LAST_RC = 2'(POOL - 1);

  typedef enum logic [2:0] {IDLE, READ, WAIT, EMIT, DONE} state_t;

  state_t                   state, state_nxt;
  logic [1:0]               sub;              // word index within the window, 0..3
  logic [1:0]               chan, prow, pcol;
  logic                     rd_vld_q;         // rd_data holds a word this cycle
  logic                     rd_first_q;       // that word is the window's first
  logic signed [DWIDTH-1:0] max_q;
  logic                     is_last;
  logic                     xfer;
  logic [5:0]               row_i, col_i, pos;

  assign is_last = (chan == LAST_CH) && (prow == LAST_RC) && (pcol == LAST_RC);
  assign xfer    = (state == EMIT) && out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = READ;
      READ: begin
        rd_en = 1'b1;
        busy  = 1'b1;
        if (sub == 2'd3) state_nxt = WAIT;
      end
      WAIT: begin
        busy      = 1'b1;
        state_nxt = EMIT;
      end
      EMIT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_last  = is_last;
        if (out_ready) state_nxt = is_last ? DONE : READ;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Window word order (0,0),(0,1),(1,0),(1,1): sub[1] picks the row, sub[0] the column.
  always_comb begin
    row_i = {3'b000, prow, sub[1]};
    col_i = {3'b000, pcol, sub[0]};
    pos   = row_i * 6'(MAP_DIM) + col_i;
  end

  assign rd_addr = rd_en ? {chan, pos} : 8'd0;

  // Window indices only move on an accepted result, so tags stay stable under backpressure.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sub  <= 2'd0;
      chan <= 2'd0;
      prow <= 2'd0;
      pcol <= 2'd0;
    end else begin
      if (state == READ) sub <= sub + 2'd1;
      if (state == DONE) begin
        chan <= 2'd0;
        prow <= 2'd0;
        pcol <= 2'd0;
      end else if (xfer && !is_last) begin
        if (pcol == LAST_RC) begin
          pcol <= 2'd0;
          if (prow == LAST_RC) begin
            prow <= 2'd0;
            chan <= chan + 2'd1;
          end else begin
            prow <= prow + 2'd1;
          end
        end else begin
          pcol <= pcol + 2'd1;
        end
      end
    end
  end

  // The first word of a window loads unconditionally; later words replace only when
  // strictly greater, so ties keep the earlier value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_vld_q   <= 1'b0;
      rd_first_q <= 1'b0;
      max_q      <= '0;
    end else begin
      rd_vld_q   <= rd_en;
      rd_first_q <= rd_en && (sub == 2'd0);
      if (rd_vld_q && (rd_first_q || ($signed(rd_data) > max_q)))
        max_q <= $signed(rd_data);
    end
  end

  assign out_chan = chan;
  assign out_row  = prow;
  assign out_col  = pcol;

`ifdef MAXPOOL_SAT8_EN
  always_comb begin
    out_data = '0;
    if (max_q[DWIDTH-1])  out_data = '0;
    else if (max_q > 255) out_data = DWIDTH'(255);
    else                  out_data = max_q;
  end
`else
  assign out_data = max_q;
`endif

endmodule

// File: tb/tb_maxpool_2x2_stage.sv
// tb_maxpool_2x2_stage: directed bench for maxpool_2x2_stage with a 1-cycle BRAM model.
// Ramp memory with a table of hand-valued windows overlaid; full passes with and without
// backpressure, a spurious start, and an asynchronous reset mid-pass.
module tb_maxpool_2x2_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        rd_en;
  logic [7:0]  rd_addr;
  logic [16:0] rd_data = '0;
  logic        out_valid;
  logic        out_ready;
  logic [16:0] out_data;
  logic [1:0]  out_chan, out_row, out_col;
  logic        out_last, busy, done;

  maxpool_2x2_stage dut (
    .clk(clk), .reset(reset), .start(start),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_chan(out_chan), .out_row(out_row), .out_col(out_col),
    .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [16:0] mem [256];
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  typedef struct {
    int ch, r, c;
    int w0, w1, w2, w3;
    int exp_raw, exp_sat;
  } vec_t;

  vec_t        vecs [8];
  logic [16:0] got_data [27];
  int          rd_log [108];
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int addr_of(input int ch, input int r, input int c, input int k);
    return ch * 64 + (2 * r + k / 2) * 6 + 2 * c + k % 2;
  endfunction

  function automatic logic [16:0] model_win(input int ch, input int r, input int c);
    logic signed [16:0] m, w;
    m = '0;
    for (int k = 0; k < 4; k++) begin
      w = $signed(mem[8'(addr_of(ch, r, c, k))]);
      if (k == 0 || w > m) m = w;
    end
`ifdef MAXPOOL_SAT8_EN
    if (m < 0) m = 17'sd0;
    else if (m > 17'sd255) m = 17'sd255;
`endif
    return m;
  endfunction

  task automatic run_pass(input string nm, input int stall_idx, input int stall_len,
                          input int restart_cyc, input int exp_done);
    int cyc, nxfer, ndone, nrd, first_vld, done_cyc, stall_left;
    logic [23:0] hold;
    bit fin;
    cyc = 0; nxfer = 0; ndone = 0; nrd = 0; first_vld = -1; done_cyc = -1;
    stall_left = stall_len; fin = 1'b0; hold = '0;
    @(posedge clk); #1;
    start = 1'b1;
    out_ready = 1'b1;
    while (!fin && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
      start = (cyc == restart_cyc);
      out_ready = 1'b1;
      if (cyc == 1) chk({nm, " busy_c1"}, longint'(busy), 1);
      if (rd_en) begin
        if (nrd < 108) rd_log[nrd] = int'(rd_addr);
        nrd++;
      end
      if (out_valid && first_vld < 0) first_vld = cyc;
      if (out_valid && nxfer == stall_idx && stall_left > 0) begin
        out_ready = 1'b0;
        chk({nm, " stall_rd_en"}, longint'(rd_en), 0);
        if (stall_left == stall_len) hold = {out_data, out_chan, out_row, out_col, out_last};
        else chk({nm, " stall_hold"},
                 longint'({out_data, out_chan, out_row, out_col, out_last}), longint'(hold));
        stall_left--;
      end
      if (out_valid && out_ready) begin
        int ch, r, c;
        ch = nxfer / 9; r = (nxfer % 9) / 3; c = nxfer % 3;
        chk($sformatf("%s tags%0d", nm, nxfer), longint'({out_chan, out_row, out_col}),
            longint'({2'(ch), 2'(r), 2'(c)}));
        chk($sformatf("%s data%0d", nm, nxfer), longint'(out_data),
            longint'(model_win(ch, r, c)));
        chk($sformatf("%s last%0d", nm, nxfer), longint'(out_last), longint'(nxfer == 26));
        if (nxfer < 27) got_data[nxfer] = out_data;
        nxfer++;
      end
      if (done) begin
        ndone++;
        if (done_cyc < 0) done_cyc = cyc;
        chk({nm, " busy_at_done"}, longint'(busy), 0);
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 4) fin = 1'b1;
    end
    chk({nm, " finished"}, longint'(fin), 1);
    chk({nm, " first_valid_cyc"}, longint'(first_vld), 6);
    chk({nm, " transfers"}, longint'(nxfer), 27);
    chk({nm, " done_pulses"}, longint'(ndone), 1);
    chk({nm, " done_cyc"}, longint'(done_cyc), longint'(exp_done));
    chk({nm, " reads"}, longint'(nrd), 108);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    out_ready = 1'b1;

    vecs[0] = '{1, 0, 1,   -5,     -3, -100,    -7,    -3,   0};
    vecs[1] = '{1, 1, 1,  300,     12,    0,     1,   300, 255};
    vecs[2] = '{0, 2, 2,    9,      9,    4,     9,     9,   9};
    vecs[3] = '{2, 0, 0, -200,   -199, -201,  -300,  -199,   0};
    vecs[4] = '{0, 1, 0,    1,      2,    3, 65535, 65535, 255};
    vecs[5] = '{2, 2, 1, -65536,    5,   -1,     4,     5,   5};
    vecs[6] = '{1, 2, 2,    0,      0,    0,    -1,     0,   0};
    vecs[7] = '{0, 0, 2,  255,    256,   -1,     0,   256, 255};

    for (int a = 0; a < 256; a++) mem[a] = 17'(100 * (a / 64) + a % 64);
    for (int i = 0; i < 8; i++) begin
      mem[8'(addr_of(vecs[i].ch, vecs[i].r, vecs[i].c, 0))] = 17'(vecs[i].w0);
      mem[8'(addr_of(vecs[i].ch, vecs[i].r, vecs[i].c, 1))] = 17'(vecs[i].w1);
      mem[8'(addr_of(vecs[i].ch, vecs[i].r, vecs[i].c, 2))] = 17'(vecs[i].w2);
      mem[8'(addr_of(vecs[i].ch, vecs[i].r, vecs[i].c, 3))] = 17'(vecs[i].w3);
    end

    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", longint'({rd_en, rd_addr, out_valid, out_data, out_chan, out_row,
                                   out_col, out_last, busy, done}), 0);
    reset = 1'b0;

    // Full pass, ready always high.
    run_pass("p1", -1, 0, -1, 163);
    chk("ramp_first_7", longint'(got_data[0]), 7);
    chk("ramp_c2_w12_223", longint'(got_data[23]), 223);
    chk("addr_c1_0", longint'(rd_log[36]), 64);
    chk("addr_c1_1", longint'(rd_log[37]), 65);
    chk("addr_c1_2", longint'(rd_log[38]), 70);
    chk("addr_c1_3", longint'(rd_log[39]), 71);
    for (int i = 0; i < 8; i++) begin
      logic [16:0] e;
`ifdef MAXPOOL_SAT8_EN
      e = 17'(vecs[i].exp_sat);
`else
      e = 17'(vecs[i].exp_raw);
`endif
      chk($sformatf("vec%0d", i),
          longint'(got_data[vecs[i].ch * 9 + vecs[i].r * 3 + vecs[i].c]), longint'(e));
    end

    // Backpressure: 10 stall cycles on the 5th result.
    run_pass("stall", 4, 10, -1, 173);

    // Extra start while busy is ignored.
    run_pass("restart", -1, 0, 50, 163);

    // Async reset while the 11th window (chan1, 0,1) is being read.
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (61) @(posedge clk);
    #1;
    chk("pre_rst_rd_en", longint'(rd_en), 1);
    chk("pre_rst_addr", longint'(rd_addr), 67);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_reset_outputs", longint'({rd_en, rd_addr, out_valid, out_data, out_chan, out_row,
                                       out_col, out_last, busy, done}), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    run_pass("after_rst", -1, 0, -1, 163);
    chk("after_rst_first", longint'(got_data[0]), 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
